// File: rtl/fatori_mon_pkg.sv
// Shared constants and helpers for the fatori monitor error collector.
// Kind encoding is shared by the counter array and the cnt_sel_i readback port.
package fatori_mon_pkg;

  localparam logic [1:0] FM_KIND_MIN   = 2'd0;
  localparam logic [1:0] FM_KIND_MAJ   = 2'd1;
  localparam logic [1:0] FM_KIND_SCRUB = 2'd2;

  // $clog2 that never returns 0, so single-source builds still get a 1-bit index.
  function automatic int unsigned fm_clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Saturating +1 for counters of up to 32 bits; callers cast back to their width.
  function automatic logic [31:0] fm_sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fatori_mon_evt_fifo.sv
// Show-ahead synchronous FIFO with flush and drop indication.
// A push on full is accepted only when a pop happens in the same cycle.
module fatori_mon_evt_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         valid_o,
  output logic         full_o,
  output logic         drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   occ_q;
  logic          empty, do_push, do_pop;

  assign empty   = (occ_q == '0);
  assign full_o  = (occ_q == (AW+1)'(DEPTH));
  assign valid_o = !empty;

  // Flush dominates both push and pop.
  assign do_pop  = pop_i && !empty && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);
  assign drop_o  = push_i && !flush_i && full_o && !do_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      occ_q <= occ_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Gate the head so it reads 0 whenever nothing is queued.
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/fatori_mon_err_collect.sv
// Collects min/maj/scrub pulses from the hardened wrappers into saturating
// counters, sticky alert state and a timestamped event FIFO.
module fatori_mon_err_collect
  import fatori_mon_pkg::*;
#(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 16,
  parameter int unsigned TSW   = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NSRC-1:0]                  min_err_i,
  input  logic [NSRC-1:0]                  maj_err_i,
  input  logic [NSRC-1:0]                  scrub_i,
  input  logic                             clr_i,
  output logic                             evt_valid_o,
  input  logic                             evt_ready_i,
  output logic [NSRC-1:0]                  evt_min_o,
  output logic [NSRC-1:0]                  evt_maj_o,
  output logic [NSRC-1:0]                  evt_scrub_o,
  output logic [TSW-1:0]                   evt_time_o,
  input  logic [$clog2(NSRC)+1:0]          cnt_sel_i,
  output logic [CW-1:0]                    cnt_o,
  output logic                             maj_alert_o,
  output logic [fm_clog2_min1(NSRC)-1:0]   first_maj_src_o,
  output logic                             overflow_o,
  output logic [CW-1:0]                    drop_cnt_o
);

  localparam int unsigned SelW = $clog2(NSRC) + 2;
  localparam int unsigned FsW  = fm_clog2_min1(NSRC);
  localparam int unsigned EW   = 3 * NSRC + TSW;

  logic [TSW-1:0]  ts_q;
  logic [CW-1:0]   cnt_q [NSRC][3];
  logic [CW-1:0]   cnt_d [NSRC][3];
  logic            maj_alert_q;
  logic [FsW-1:0]  first_src_q;
  logic [FsW-1:0]  low_src;
  logic            overflow_q;
  logic [CW-1:0]   drop_cnt_q;
  logic            evt_cycle;
  logic [EW-1:0]   fifo_wdata, fifo_rdata;
  logic            fifo_full, fifo_drop;

  function automatic logic [CW-1:0] sat_inc_cw(input logic [CW-1:0] v);
    return CW'(fm_sat_inc(32'(v), CW));
  endfunction

  assign evt_cycle  = |{min_err_i, maj_err_i, scrub_i};
  assign fifo_wdata = {min_err_i, maj_err_i, scrub_i, ts_q};

  fatori_mon_evt_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clr_i),
    .push_i  (evt_cycle),
    .wdata_i (fifo_wdata),
    .pop_i   (evt_ready_i),
    .rdata_o (fifo_rdata),
    .valid_o (evt_valid_o),
    .full_o  (fifo_full),
    .drop_o  (fifo_drop)
  );

  assign {evt_min_o, evt_maj_o, evt_scrub_o, evt_time_o} = fifo_rdata;

  // Timestamp keeps running through clr_i so event times stay globally ordered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + TSW'(1);
  end

  always_comb begin
    for (int s = 0; s < int'(NSRC); s++) begin
      for (int k = 0; k < 3; k++) begin
        cnt_d[s][k] = cnt_q[s][k];
      end
      if (clr_i) begin
        for (int k = 0; k < 3; k++) begin
          cnt_d[s][k] = '0;
        end
      end else begin
        if (min_err_i[s]) cnt_d[s][FM_KIND_MIN]   = sat_inc_cw(cnt_q[s][FM_KIND_MIN]);
        if (maj_err_i[s]) cnt_d[s][FM_KIND_MAJ]   = sat_inc_cw(cnt_q[s][FM_KIND_MAJ]);
        if (scrub_i[s])   cnt_d[s][FM_KIND_SCRUB] = sat_inc_cw(cnt_q[s][FM_KIND_SCRUB]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(NSRC); s++) begin
        for (int k = 0; k < 3; k++) begin
          cnt_q[s][k] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < int'(NSRC); s++) begin
        for (int k = 0; k < 3; k++) begin
          cnt_q[s][k] <= cnt_d[s][k];
        end
      end
    end
  end

  // Lowest set index wins, so scan from the top down.
  always_comb begin
    low_src = '0;
    for (int s = int'(NSRC) - 1; s >= 0; s--) begin
      if (maj_err_i[s]) low_src = FsW'(s);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      maj_alert_q <= 1'b0;
      first_src_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else if (clr_i) begin
      maj_alert_q <= 1'b0;
      first_src_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (!maj_alert_q && |maj_err_i) begin
        maj_alert_q <= 1'b1;
        first_src_q <= low_src;
      end
      if (fifo_drop) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= sat_inc_cw(drop_cnt_q);
      end
    end
  end

  assign maj_alert_o     = maj_alert_q;
  assign first_maj_src_o = first_src_q;
  assign overflow_o      = overflow_q;
  assign drop_cnt_o      = drop_cnt_q;

  always_comb begin
    logic [SelW-1:0] sel_src;
    cnt_o   = '0;
    sel_src = cnt_sel_i >> 2;
    for (int s = 0; s < int'(NSRC); s++) begin
      if (sel_src == SelW'(s)) begin
        unique case (cnt_sel_i[1:0])
          FM_KIND_MIN:   cnt_o = cnt_q[s][FM_KIND_MIN];
          FM_KIND_MAJ:   cnt_o = cnt_q[s][FM_KIND_MAJ];
          FM_KIND_SCRUB: cnt_o = cnt_q[s][FM_KIND_SCRUB];
          default:       cnt_o = '0;
        endcase
      end
    end
  end

  // fifo_full is only consumed inside the FIFO's own drop logic.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fatori_mon_err_collect.sv
// Directed bench for fatori_mon_err_collect (NSRC=4, DEPTH=8, CW=4, TSW=32).
module tb_fatori_mon_err_collect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  min_err, maj_err, scrub;
  logic        clr;
  logic        evt_valid, evt_ready;
  logic [3:0]  evt_min, evt_maj, evt_scrub;
  logic [31:0] evt_time;
  logic [3:0]  cnt_sel;
  logic [3:0]  cnt;
  logic        maj_alert;
  logic [1:0]  first_maj_src;
  logic        overflow;
  logic [3:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference cycle count: value the DUT timestamp should hold right now.
  logic [31:0] ref_cyc;
  logic [31:0] ts_arr [10];
  logic [31:0] exp_t, prev_t, t_new;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_cyc <= '0;
    else        ref_cyc <= ref_cyc + 32'd1;
  end

  fatori_mon_err_collect #(
    .NSRC  (4),
    .DEPTH (8),
    .CW    (4),
    .TSW   (32)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .min_err_i       (min_err),
    .maj_err_i       (maj_err),
    .scrub_i         (scrub),
    .clr_i           (clr),
    .evt_valid_o     (evt_valid),
    .evt_ready_i     (evt_ready),
    .evt_min_o       (evt_min),
    .evt_maj_o       (evt_maj),
    .evt_scrub_o     (evt_scrub),
    .evt_time_o      (evt_time),
    .cnt_sel_i       (cnt_sel),
    .cnt_o           (cnt),
    .maj_alert_o     (maj_alert),
    .first_maj_src_o (first_maj_src),
    .overflow_o      (overflow),
    .drop_cnt_o      (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] sel, input logic [3:0] exp);
    cnt_sel = sel;
    #1;
    check(tag, 64'(cnt), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; min_err = '0; maj_err = '0; scrub = '0;
    clr = 1'b0; evt_ready = 1'b0; cnt_sel = '0;
    tick(); tick();
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_alert", 64'(maj_alert), 64'd0);
    check("rst_first", 64'(first_maj_src), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_time", 64'(evt_time), 64'd0);
    check_cnt("rst_cnt", 4'b0000, 4'd0);
    rst_n = 1'b1;
    tick();

    // Single maj pulse on source 2.
    maj_err = 4'b0100;
    exp_t = ref_cyc;
    tick();
    maj_err = '0;
    check("maj_valid", 64'(evt_valid), 64'd1);
    check("maj_vec", 64'(evt_maj), 64'h4);
    check("maj_min_vec", 64'(evt_min), 64'h0);
    check("maj_time", 64'(evt_time), 64'(exp_t));
    check("maj_alert", 64'(maj_alert), 64'd1);
    check("maj_first", 64'(first_maj_src), 64'd2);
    check_cnt("maj_cnt_2_1", 4'b1001, 4'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("maj_popped", 64'(evt_valid), 64'd0);

    // Streaming: min on source 0 for 5 cycles with ready held high.
    evt_ready = 1'b1;
    prev_t = '0;
    for (int i = 0; i < 5; i++) begin
      min_err = 4'b0001;
      exp_t = ref_cyc;
      tick();
      check("stream_valid", 64'(evt_valid), 64'd1);
      check("stream_time", 64'(evt_time), 64'(exp_t));
      if (i > 0) check("stream_consec", 64'(evt_time), 64'(prev_t + 32'd1));
      prev_t = evt_time;
    end
    min_err = '0;
    tick();
    evt_ready = 1'b0;
    check("stream_empty", 64'(evt_valid), 64'd0);
    check_cnt("stream_cnt_0_0", 4'b0000, 4'd5);

    // Overflow: 10 events into an 8-deep FIFO with no consumer.
    for (int i = 0; i < 10; i++) begin
      min_err = 4'b0010;
      ts_arr[i] = ref_cyc;
      tick();
    end
    min_err = '0;
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_valid", 64'(evt_valid), 64'd1);
    check("ovf_head_time", 64'(evt_time), 64'(ts_arr[0]));
    check("ovf_head_min", 64'(evt_min), 64'h2);
    tick();
    check("ovf_head_stable", 64'(evt_time), 64'(ts_arr[0]));

    // Full with simultaneous pop and push: nothing dropped.
    scrub = 4'b1000;
    evt_ready = 1'b1;
    t_new = ref_cyc;
    tick();
    scrub = '0;
    check("fullpp_drop", 64'(drop_cnt), 64'd2);
    for (int i = 1; i <= 8; i++) begin
      exp_t = (i == 8) ? t_new : ts_arr[i];
      check("drain_valid", 64'(evt_valid), 64'd1);
      check("drain_time", 64'(evt_time), 64'(exp_t));
      if (i == 8) check("drain_tail_scrub", 64'(evt_scrub), 64'h8);
      tick();
    end
    check("drain_empty", 64'(evt_valid), 64'd0);
    check("drain_drop_kept", 64'(drop_cnt), 64'd2);
    check_cnt("cnt_1_0", 4'b0100, 4'd10);
    check_cnt("cnt_3_2", 4'b1110, 4'd1);
    check_cnt("cnt_kind3", 4'b0111, 4'd0);

    // Saturation: 20 scrub pulses on source 1 with CW=4.
    for (int i = 0; i < 20; i++) begin
      scrub = 4'b0010;
      tick();
    end
    scrub = '0;
    check_cnt("sat_cnt_1_2", 4'b0110, 4'd15);

    // clr_i with a simultaneous maj pulse: clear wins.
    clr = 1'b1;
    maj_err = 4'b0001;
    tick();
    clr = 1'b0;
    maj_err = '0;
    evt_ready = 1'b0;
    check("clr_valid", 64'(evt_valid), 64'd0);
    check("clr_alert", 64'(maj_alert), 64'd0);
    check("clr_first", 64'(first_maj_src), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_drop", 64'(drop_cnt), 64'd0);
    check_cnt("clr_cnt_1_2", 4'b0110, 4'd0);
    check_cnt("clr_cnt_1_0", 4'b0100, 4'd0);
    check_cnt("clr_cnt_2_1", 4'b1001, 4'd0);
    check_cnt("clr_cnt_0_1", 4'b0001, 4'd0);
    check_cnt("clr_cnt_0_0", 4'b0000, 4'd0);

    // Async reset mid-drain with 3 entries queued.
    for (int i = 0; i < 3; i++) begin
      min_err = 4'b0100;
      tick();
    end
    min_err = '0;
    check("pre_rst_valid", 64'(evt_valid), 64'd1);
    check_cnt("pre_rst_cnt_2_0", 4'b1000, 4'd3);
    evt_ready = 1'b1;
    tick();
    check("pre_rst_still_valid", 64'(evt_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(evt_valid), 64'd0);
    evt_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_valid", 64'(evt_valid), 64'd0);
    check("post_rst_time", 64'(evt_time), 64'd0);
    check("post_rst_min", 64'(evt_min), 64'd0);
    check("post_rst_alert", 64'(maj_alert), 64'd0);
    check("post_rst_first", 64'(first_maj_src), 64'd0);
    check("post_rst_ovf", 64'(overflow), 64'd0);
    check("post_rst_drop", 64'(drop_cnt), 64'd0);
    check_cnt("post_rst_cnt_2_0", 4'b1000, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fatori_mon_err_collect.md
Name: fatori_mon_err_collect

Overview:
Error-event collector that sits directly downstream of the hardened wrappers (LSU, and peers) and consumes their per-cycle min_err, maj_err and scrub_occurred pulses. It keeps saturating per-source counters and sticky major-error alert state. It logs every non-empty error cycle, with a timestamp, into an event FIFO that is drained over a valid/ready interface by the debug/monitor side.

Parameters:
NSRC, 4, number of monitored wrappers (source index 0 = LSU wrapper), 1..16
DEPTH, 8, event FIFO entries, power of two, >= 2
CW, 16, width of each saturating counter
TSW, 32, timestamp width (free-running cycle counter)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
min_err_i  in  NSRC  per-source minority-disagreement pulse
maj_err_i  in  NSRC  per-source majority-failure pulse
scrub_i  in  NSRC  per-source scrub-occurred pulse
clr_i  in  1  synchronous clear of counters, sticky state and FIFO
evt_valid_o  out  1  FIFO head valid
evt_ready_i  in  1  consumer accepts head
evt_min_o  out  NSRC  head entry min vector
evt_maj_o  out  NSRC  head entry maj vector
evt_scrub_o  out  NSRC  head entry scrub vector
evt_time_o  out  TSW  head entry timestamp
cnt_sel_i  in  $clog2(NSRC)+2  {source, kind}: kind 0=min, 1=maj, 2=scrub, 3=reserved
cnt_o  out  CW  selected counter (combinational mux; kind 3 or source >= NSRC reads 0)
maj_alert_o  out  1  sticky: any maj_err seen since reset/clear
first_maj_src_o  out  $clog2(NSRC) (min 1)  lowest-index source of the first maj cycle
overflow_o  out  1  sticky: at least one event dropped on full FIFO
drop_cnt_o  out  CW  saturating count of dropped events

Behaviour:
- Reset (rst_ni low, asynchronous): all counters, timestamp, FIFO pointers and occupancy, and sticky flags go to 0. Outputs: evt_valid_o=0, maj_alert_o=0, first_maj_src_o=0, overflow_o=0, drop_cnt_o=0, cnt_o=0. Head data fields are don't-care while evt_valid_o=0 but are driven to 0 after reset.
- Timestamp: free-running TSW-bit counter. Increments every cycle and wraps 2^TSW-1 -> 0. clr_i does not reset it.
- Event cycle: any bit of {min_err_i, maj_err_i, scrub_i} is high. The entry is {min, maj, scrub vectors, current timestamp}, and one push is made per event cycle.
- Latency: an event sampled at edge t gives evt_valid_o high after edge t (visible cycle t+1) when the FIFO was empty. Show-ahead head; no bubble.
- Handshake: pop occurs when evt_valid_o && evt_ready_i. Head data is stable while valid && !ready. ready while empty is ignored.
- Full: a push with the FIFO full and no same-cycle pop drops the entry, sets overflow_o, and increments drop_cnt_o (saturating at 2^CW-1).
- Full with same-cycle pop and push: both happen, occupancy stays DEPTH, nothing is dropped.
- Empty with same-cycle push and pop: the pop is not possible (valid=0), so only the push occurs.
- Counters: per source s, per kind, +1 for each cycle the matching input bit is high. Counters saturate at 2^CW-1 and never wrap.
- maj_alert_o: set the cycle after the first maj pulse. On that same edge, first_maj_src_o captures the lowest index set in maj_err_i. Later maj pulses do not change first_maj_src_o until clr_i.
- clr_i (synchronous): zeroes counters, drop_cnt_o, overflow_o, maj_alert_o and first_maj_src_o, and flushes the FIFO (evt_valid_o=0 next cycle). clr_i dominates: an event or pop in the same cycle is discarded and not counted.
- Reset mid-operation: the asynchronous reset clears everything immediately. An in-flight handshake is abandoned and the consumer must observe evt_valid_o=0.
- Inputs are synchronous to clk_i. The block does not synchronise them.

Decomposition:
- Package fatori_mon_pkg holds:
  - kind encoding constants FM_KIND_MIN=2'd0, FM_KIND_MAJ=2'd1, FM_KIND_SCRUB=2'd2;
  - a function for saturating increment;
  - a localparam helper for the minimum-1 clog2.
- Sub-module fatori_mon_evt_fifo: generic show-ahead synchronous FIFO with parameters W and DEPTH, push/pop/flush, and full/empty/overflow-drop indication. The collector instantiates it with W = 3*NSRC+TSW.

Test Plan:
- Reset, then maj_err_i=4'b0100 for one cycle -> next cycle: evt_valid_o=1, evt_maj_o=4'b0100, maj_alert_o=1, first_maj_src_o=2; cnt_sel={2,1} gives cnt_o=1.
- min_err_i=4'b0001 held 5 cycles with evt_ready_i=1 -> 5 entries popped with consecutive evt_time_o values; counter {0,0}=5.
- evt_ready_i=0, 10 consecutive event cycles with DEPTH=8 -> 8 entries held, overflow_o=1, drop_cnt_o=2; then drain yields the first 8 timestamps in order.
- FIFO full, and in the same cycle evt_ready_i=1 plus a new event -> occupancy stays 8, drop_cnt_o unchanged, the newest entry is at the tail.
- Counter forced near the top (CW=4): 20 scrub pulses on source 1 -> cnt_o=15; then clr_i plus a simultaneous maj pulse -> all counters 0, maj_alert_o=0, evt_valid_o=0.
- Assert rst_ni low asynchronously mid-drain with 3 entries queued -> evt_valid_o=0 immediately; after release all outputs are 0.
